// File: rtl/cpm_cnt_bank.sv
// Multi-channel event counter bank with wrap/saturate modes, preload, a coherent
// shadow snapshot, a one-cycle read port and sticky overflow flags with a combined interrupt.
module cpm_cnt_bank #(
  parameter  int NCH = 4,
  parameter  int DW  = 16,
  localparam int AW  = $clog2(NCH)
) (
  input  logic           Clk,
  input  logic           Rstn,
  input  logic [NCH-1:0] Enable,
  input  logic           Mode,
  input  logic           Clr,
  input  logic           Load,
  input  logic [AW-1:0]  LoadCh,
  input  logic [DW-1:0]  LoadVal,
  input  logic           Snap,
  input  logic           RdReq,
  input  logic [AW-1:0]  RdCh,
  output logic           RdVld,
  output logic [DW-1:0]  RdData,
  output logic [NCH-1:0] Ovf,
  output logic           OvfIrq
);

  localparam logic [DW-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0] CNT_ONE = DW'(1);

  logic [DW-1:0]  cnt    [NCH];
  logic [DW-1:0]  shadow [NCH];
  logic [NCH-1:0] load_hit;
  logic [DW-1:0]  rd_sel;

  // Load decode; a LoadCh beyond the last channel matches nothing and is ignored.
  // NOTE: combinational blocks assign defaults first and use blocking '=' so no latch is inferred.
  always_comb begin
    load_hit = '0;
    for (int i = 0; i < NCH; i++) begin
      load_hit[i] = Load && (LoadCh == AW'(i));
    end
  end

  // Per-channel counter and sticky overflow: Clr > Load > Enable > hold.
  // NOTE: the counter and shadow arrays are small flop banks, not RAM, so they take the async reset.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < NCH; i++) begin
        cnt[i] <= '0;
      end
      Ovf <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (Clr) begin
          cnt[i] <= '0;
          Ovf[i] <= 1'b0;
        end else if (load_hit[i]) begin
          cnt[i] <= LoadVal;
        end else if (Enable[i]) begin
          if (cnt[i] == CNT_MAX) begin
            Ovf[i] <= 1'b1;
            if (!Mode) begin
              cnt[i] <= '0;
            end
          end else begin
            cnt[i] <= cnt[i] + CNT_ONE;
          end
        end
      end
    end
  end

  // Shadow captures the pre-update counter values, so Snap with Clr keeps the old counts.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= '0;
      end
    end else if (Snap) begin
      for (int i = 0; i < NCH; i++) begin
        shadow[i] <= cnt[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      OvfIrq <= 1'b0;
    end else begin
      OvfIrq <= |Ovf;
    end
  end

  // Read mux over the shadow bank; an out-of-range channel selects zero.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NCH; i++) begin
      if (RdCh == AW'(i)) begin
        rd_sel = shadow[i];
      end
    end
  end

  // Read pipeline: RdData only moves on a request, so it holds while RdVld is low.
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      RdVld  <= 1'b0;
      RdData <= '0;
    end else begin
      RdVld <= RdReq;
      if (RdReq) begin
        RdData <= rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_cpm_cnt_bank.sv
// Scoreboard bench for cpm_cnt_bank: a 4-channel bank plus a 3-channel bank sharing stimulus,
// the latter exercising out-of-range load and read channels.
module tb_cpm_cnt_bank;

  localparam int NCH  = 4;
  localparam int NCH3 = 3;
  localparam int DW   = 4;
  localparam int AW   = 2;
  localparam logic [DW-1:0] MAXV = 4'd15;

  logic           Clk;
  logic           Rstn;
  logic [NCH-1:0] Enable;
  logic           Mode;
  logic           Clr;
  logic           Load;
  logic [AW-1:0]  LoadCh;
  logic [DW-1:0]  LoadVal;
  logic           Snap;
  logic           RdReq;
  logic [AW-1:0]  RdCh;

  logic            RdVld,  b_rd_vld;
  logic [DW-1:0]   RdData, b_rd_data;
  logic [NCH-1:0]  Ovf;
  logic [NCH3-1:0] b_ovf;
  logic            OvfIrq, b_ovf_irq;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DW-1:0]  mdl_cnt    [NCH];
  logic [DW-1:0]  mdl_shadow [NCH];
  logic [NCH-1:0] mdl_ovf;
  logic           mdl_irq, mdl_irq3;
  logic           exp_vld;
  logic [DW-1:0]  last_rd, last_rd3;
  logic [DW-1:0]  sb_q  [$];
  logic [DW-1:0]  sb3_q [$];
  logic [DW-1:0]  pop_d, pop3_d;
  logic           mon_en = 1'b0;

  cpm_cnt_bank #(.NCH(NCH), .DW(DW)) u_dut (
    .Clk(Clk), .Rstn(Rstn), .Enable(Enable), .Mode(Mode), .Clr(Clr),
    .Load(Load), .LoadCh(LoadCh), .LoadVal(LoadVal), .Snap(Snap),
    .RdReq(RdReq), .RdCh(RdCh), .RdVld(RdVld), .RdData(RdData),
    .Ovf(Ovf), .OvfIrq(OvfIrq)
  );

  cpm_cnt_bank #(.NCH(NCH3), .DW(DW)) u_dut3 (
    .Clk(Clk), .Rstn(Rstn), .Enable(Enable[NCH3-1:0]), .Mode(Mode), .Clr(Clr),
    .Load(Load), .LoadCh(LoadCh), .LoadVal(LoadVal), .Snap(Snap),
    .RdReq(RdReq), .RdCh(RdCh), .RdVld(b_rd_vld), .RdData(b_rd_data),
    .Ovf(b_ovf), .OvfIrq(b_ovf_irq)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      mdl_cnt[i]    = '0;
      mdl_shadow[i] = '0;
    end
    mdl_ovf  = '0;
    mdl_irq  = 1'b0;
    mdl_irq3 = 1'b0;
    exp_vld  = 1'b0;
    last_rd  = '0;
    last_rd3 = '0;
    sb_q.delete();
    sb3_q.delete();
  endtask

  // Applies the inputs held across the current edge to the model.
  task automatic model_update();
    if (RdReq) begin
      sb_q.push_back(mdl_shadow[RdCh]);
      sb3_q.push_back((RdCh < 2'd3) ? mdl_shadow[RdCh] : '0);
    end
    exp_vld  = RdReq;
    mdl_irq  = |mdl_ovf;
    mdl_irq3 = |mdl_ovf[NCH3-1:0];
    if (Snap) mdl_shadow = mdl_cnt;
    for (int i = 0; i < NCH; i++) begin
      if (Clr) begin
        mdl_cnt[i] = '0;
        mdl_ovf[i] = 1'b0;
      end else if (Load && int'(LoadCh) == i) begin
        mdl_cnt[i] = LoadVal;
      end else if (Enable[i]) begin
        if (mdl_cnt[i] == MAXV) begin
          mdl_ovf[i] = 1'b1;
          mdl_cnt[i] = Mode ? MAXV : 4'd0;
        end else begin
          mdl_cnt[i] = mdl_cnt[i] + 4'd1;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    model_update();
    #1;
    Enable = '0;
    Clr    = 1'b0;
    Load   = 1'b0;
    Snap   = 1'b0;
    RdReq  = 1'b0;
  endtask

  task automatic read(input int ch);
    RdReq = 1'b1;
    RdCh  = AW'(ch);
    tick();
  endtask

  task automatic load(input int ch, input int val);
    Load    = 1'b1;
    LoadCh  = AW'(ch);
    LoadVal = DW'(val);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_vld"},   RdVld,     0);
    check({tag, "_rd_data"},  RdData,    0);
    check({tag, "_ovf"},      Ovf,       0);
    check({tag, "_ovf_irq"},  OvfIrq,    0);
    check({tag, "_rd_vld3"},  b_rd_vld,  0);
    check({tag, "_rd_data3"}, b_rd_data, 0);
    check({tag, "_ovf3"},     b_ovf,     0);
    check({tag, "_ovf_irq3"}, b_ovf_irq, 0);
  endtask

  // Output monitor on the falling edge, away from the active edge.
  always @(negedge Clk) begin
    if (mon_en) begin
      check("ovf",      Ovf,       mdl_ovf);
      check("ovf_irq",  OvfIrq,    mdl_irq);
      check("rd_vld",   RdVld,     exp_vld);
      check("ovf3",     b_ovf,     mdl_ovf[NCH3-1:0]);
      check("ovf_irq3", b_ovf_irq, mdl_irq3);
      check("rd_vld3",  b_rd_vld,  exp_vld);
      if (RdVld) begin
        check("sb_pending", sb_q.size() != 0, 1);
        if (sb_q.size() != 0) begin
          pop_d = sb_q.pop_front();
          check("rd_data", RdData, pop_d);
          last_rd = pop_d;
        end
      end else begin
        check("rd_hold", RdData, last_rd);
      end
      if (b_rd_vld) begin
        check("sb3_pending", sb3_q.size() != 0, 1);
        if (sb3_q.size() != 0) begin
          pop3_d = sb3_q.pop_front();
          check("rd_data3", b_rd_data, pop3_d);
          last_rd3 = pop3_d;
        end
      end else begin
        check("rd_hold3", b_rd_data, last_rd3);
      end
    end
  end

  initial begin
    Rstn    = 1'b0;
    Enable  = '0;
    Mode    = 1'b0;
    Clr     = 1'b0;
    Load    = 1'b0;
    LoadCh  = '0;
    LoadVal = '0;
    Snap    = 1'b0;
    RdReq   = 1'b0;
    RdCh    = '0;
    model_reset();
    #2;
    check_all_zero("reset");
    #5;
    Rstn   = 1'b1;
    mon_en = 1'b1;

    // Basic count, snapshot, read every channel back-to-back (ch3 is out of range on u_dut3)
    repeat (5) begin
      Enable = 4'b0001;
      tick();
    end
    Snap = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) read(c);
    tick();

    // Wrap mode on ch1: 15, 0, 1, observed through snapshots; Snap+RdReq returns old shadow
    Mode = 1'b0;
    load(1, 14);
    Enable = 4'b0010; tick();
    Enable = 4'b0010; Snap = 1'b1; tick();
    Enable = 4'b0010; Snap = 1'b1; RdReq = 1'b1; RdCh = 2'd1; tick();
    Snap = 1'b1; RdReq = 1'b1; RdCh = 2'd1; tick();
    read(1);
    tick();

    // Saturate mode on ch2: 15, 15, 15
    Clr = 1'b1;
    tick();
    Mode = 1'b1;
    load(2, 14);
    Enable = 4'b0100; tick();
    Enable = 4'b0100; Snap = 1'b1; tick();
    Enable = 4'b0100; Snap = 1'b1; RdReq = 1'b1; RdCh = 2'd2; tick();
    Snap = 1'b1; RdReq = 1'b1; RdCh = 2'd2; tick();
    read(2);
    Mode = 1'b0;

    // Clr + Load + Enable + Snap together; load to ch3 is ignored by the 3-channel bank
    load(0, 3);
    load(1, 7);
    load(3, 11);
    repeat (2) begin
      Enable = 4'b1000;
      tick();
    end
    Clr = 1'b1; Load = 1'b1; LoadCh = 2'd0; LoadVal = 4'd9; Enable = 4'b1111; Snap = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) read(c);
    Snap = 1'b1;
    tick();
    for (int c = 0; c < NCH; c++) read(c);
    tick();

    // Asynchronous reset with a read in flight and an overflow set
    load(0, 15);
    Enable = 4'b0001; Snap = 1'b1; tick();
    Enable = 4'b0001; RdReq = 1'b1; RdCh = 2'd0; tick();
    Enable = 4'b0001; RdReq = 1'b1; RdCh = 2'd0; tick();
    #1;
    Rstn = 1'b0;
    model_reset();
    #1;
    check_all_zero("async_rst");
    #4;
    Rstn = 1'b1;
    repeat (3) begin
      Enable = 4'b0001;
      tick();
    end
    Snap = 1'b1;
    tick();
    read(0);
    read(1);
    repeat (2) tick();

    check("sb_drain",  sb_q.size(),  0);
    check("sb3_drain", sb3_q.size(), 0);
    mon_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
